// File: rtl/audio_pkg.sv
// Shared types and constants for the audio fill path: scheduler state encoding,
// default FIFO sizing and the LRCK synchronizer depth.
package audio_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    TRIG = 3'd1,
    WAIT = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4
  } sched_state_t;

  localparam int DEF_FIFO_WIDTH = 6;
  localparam int SYNC_LATENCY   = 2;

endpackage

// File: rtl/syncro_2.sv
// Multi-flop synchronizer for a single-bit level crossing into the clk domain.
module syncro_2 #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/audio_fill_sched.sv
// Per-period trigger sequencer for the synth engine -> L/R sample FIFO fill path,
// with I2S free-run fallback. Sticky overrun flag built when AUD_SCHED_OVERRUN_EN is defined.
module audio_fill_sched
  import audio_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int TRIG_GAP   = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [FIFO_WIDTH:0] buffersize,
  input  logic                cycle_start,
  input  logic                lrck,
  input  logic                engine_done,
  input  logic [FIFO_WIDTH:0] fifo_level,
`ifdef AUD_SCHED_OVERRUN_EN
  input  logic                overrun_clr,
  output logic                overrun,
`endif
  output logic                trig,
  output logic                i2s_enable,
  output logic                busy,
  output logic                cycle_done,
  output logic [FIFO_WIDTH:0] sample_count
);

  localparam int               CNT_W      = FIFO_WIDTH + 1;
  localparam logic [CNT_W-1:0] FIFO_DEPTH = CNT_W'(2 ** FIFO_WIDTH);
  localparam int               GAP_W      = (TRIG_GAP > 2) ? $clog2(TRIG_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'((TRIG_GAP > 0) ? TRIG_GAP - 1 : 0);

  sched_state_t     state;
  logic [CNT_W-1:0] bs_q;
  logic [CNT_W-1:0] cnt_next;
  logic [GAP_W-1:0] gap_cnt;
  logic             fifo_room;
  logic             start_ok;
  logic             i2s_mode;
  logic             lrck_s_p0;
  logic             lrck_s_p1;
  logic             lrck_rise;

  // Stage p0: LRCK resynchronized into clk
  syncro_2 #(
    .STAGES (SYNC_LATENCY)
  ) u_lrck_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (lrck),
    .q       (lrck_s_p0)
  );

  // Stage p1: previous synced level for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lrck_s_p1 <= 1'b0;
    else          lrck_s_p1 <= lrck_s_p0;
  end

  assign lrck_rise  = lrck_s_p0 & ~lrck_s_p1;
  assign fifo_room  = (fifo_level < FIFO_DEPTH);
  assign start_ok   = cycle_start && (buffersize != '0);
  assign i2s_mode   = (state == IDLE) && (buffersize == '0);
  assign cnt_next   = sample_count + CNT_W'(1);
  assign busy       = (state != IDLE);
  assign i2s_enable = i2s_mode;

  // bs_q is only consulted in WAIT, after it has been loaded on period start
  always_ff @(posedge clk) begin
    if (state == IDLE && start_ok) bs_q <= buffersize;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      trig         <= 1'b0;
      cycle_done   <= 1'b0;
      sample_count <= '0;
      gap_cnt      <= '0;
    end else begin
      trig       <= 1'b0;
      cycle_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_ok) begin
            sample_count <= '0;
            state        <= TRIG;
          end else if (i2s_mode && lrck_rise) begin
            trig <= 1'b1;
          end
        end
        TRIG: begin
          if (fifo_room) begin
            trig  <= 1'b1;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (engine_done) begin
            sample_count <= cnt_next;
            if (cnt_next == bs_q) begin
              cycle_done <= 1'b1;
              state      <= DONE;
            end else if (TRIG_GAP == 0) begin
              state <= TRIG;
            end else begin
              gap_cnt <= '0;
              state   <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) state <= TRIG;
          else                     gap_cnt <= gap_cnt + GAP_W'(1);
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AUD_SCHED_OVERRUN_EN
  // A new period requested before the current one finished; set beats clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          overrun <= 1'b0;
    else if (cycle_start && state != IDLE) overrun <= 1'b1;
    else if (overrun_clr)                  overrun <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_audio_fill_sched.sv
// Directed-plus-random bench for audio_fill_sched with a cycle-level timing reference.
module tb_audio_fill_sched;

  localparam int FW = 6;
  localparam int CW = FW + 1;
  localparam int TG = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [CW-1:0] buffersize;
  logic [CW-1:0] fifo_level;
  logic [CW-1:0] sample_count;
  logic          cycle_start;
  logic          lrck;
  logic          engine_done;
  logic          resp_done;
  logic          tb_done;
  logic          trig;
  logic          i2s_enable;
  logic          busy;
  logic          cycle_done;
`ifdef AUD_SCHED_OVERRUN_EN
  logic          overrun_clr;
  logic          overrun;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int trig_q[$];
  int done_q[$];
  int cdone_q[$];
  int busy_fall = -1;
  int double_trig = 0;
  bit resp_en = 1'b0;
  int resp_dmin = 0;
  int resp_dmax = 0;

  assign engine_done = resp_done | tb_done;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  audio_fill_sched #(
    .FIFO_WIDTH (FW),
    .TRIG_GAP   (TG)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .buffersize   (buffersize),
    .cycle_start  (cycle_start),
    .lrck         (lrck),
    .engine_done  (engine_done),
    .fifo_level   (fifo_level),
`ifdef AUD_SCHED_OVERRUN_EN
    .overrun_clr  (overrun_clr),
    .overrun      (overrun),
`endif
    .trig         (trig),
    .i2s_enable   (i2s_enable),
    .busy         (busy),
    .cycle_done   (cycle_done),
    .sample_count (sample_count)
  );

  // Observer: logs the cycle number of every trig / cycle_done and the busy fall
  initial begin
    bit prev_trig;
    bit prev_busy;
    prev_trig = 1'b0;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (trig === 1'b1) trig_q.push_back(cyc);
      if (trig === 1'b1 && prev_trig) double_trig++;
      if (cycle_done === 1'b1) cdone_q.push_back(cyc);
      if (prev_busy && busy === 1'b0) busy_fall = cyc;
      prev_trig = (trig === 1'b1);
      prev_busy = (busy === 1'b1);
    end
  end

  // Engine model: answers each trig with one engine_done pulse after a random delay
  initial begin
    int d;
    resp_done = 1'b0;
    forever begin
      @(negedge clk);
      if (trig === 1'b1 && resp_en) begin
        d = $urandom_range(resp_dmax, resp_dmin);
        repeat (d) @(negedge clk);
        resp_done = 1'b1;
        done_q.push_back(cyc);
        @(negedge clk);
        resp_done = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_period(input int b, output int s);
    trig_q.delete();
    done_q.delete();
    cdone_q.delete();
    busy_fall   = -1;
    buffersize  = CW'(b);
    cycle_start = 1'b1;
    s = cyc;
    tick();
    cycle_start = 1'b0;
  endtask

  // Reference: b trigs, trig k+1 exactly TG+2 cycles after done k,
  // cycle_done 1 cycle after the last done, busy low 1 cycle after that
  task automatic finish_period(input int b, input int first_exp, input string tag);
    int n;
    int bad;
    for (n = 0; n < 5000; n++) begin
      if (cdone_q.size() != 0 && busy_fall >= 0) break;
      tick();
    end
    chk({tag, "_timeout"}, n < 5000, 1);
    repeat (4) tick();
    chk({tag, "_trigs"}, trig_q.size(), b);
    chk({tag, "_dones"}, done_q.size(), b);
    chk({tag, "_cycle_done"}, cdone_q.size(), 1);
    chk({tag, "_count"}, sample_count, b);
    if (trig_q.size() > 0) chk({tag, "_first_trig"}, trig_q[0], first_exp);
    bad = 0;
    for (int i = 1; i < trig_q.size() && i <= done_q.size(); i++)
      if (trig_q[i] != done_q[i-1] + TG + 2) bad++;
    chk({tag, "_gap_timing"}, bad, 0);
    if (done_q.size() > 0 && cdone_q.size() > 0) begin
      chk({tag, "_done_latency"}, cdone_q[0], done_q[$] + 1);
      chk({tag, "_busy_fall"}, busy_fall, cdone_q[0] + 1);
    end
  endtask

  initial begin
    int s;
    int f;
    int n;
    int b;
    int r[3];

    reset_n     = 1'b0;
    buffersize  = '0;
    fifo_level  = '0;
    cycle_start = 1'b0;
    lrck        = 1'b0;
    tb_done     = 1'b0;
`ifdef AUD_SCHED_OVERRUN_EN
    overrun_clr = 1'b0;
`endif

    // Reset state
    repeat (2) tick();
    chk("rst_trig", trig, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cycle_done", cycle_done, 0);
    chk("rst_count", sample_count, 0);
    chk("rst_i2s_bs0", i2s_enable, 1);
`ifdef AUD_SCHED_OVERRUN_EN
    chk("rst_overrun", overrun, 0);
`endif
    buffersize = CW'(5);
    #1;
    chk("rst_i2s_bs5", i2s_enable, 0);
    reset_n = 1'b1;
    tick();

    // Basic period: 4 samples, engine answers 5 cycles after each trig
    resp_en   = 1'b1;
    resp_dmin = 5;
    resp_dmax = 5;
    fifo_level = CW'(10);
    start_period(4, s);
    finish_period(4, s + 2, "basic");

    // Random periods, including engine_done in the same cycle as trig
    for (int k = 0; k < 4; k++) begin
      b = $urandom_range(12, 1);
      resp_dmin  = 0;
      resp_dmax  = 6;
      fifo_level = CW'($urandom_range(63, 0));
      start_period(b, s);
      finish_period(b, s + 2, $sformatf("rand%0d", k));
    end

    // FIFO full stall, then release
    resp_dmin  = 1;
    resp_dmax  = 4;
    fifo_level = CW'(64);
    start_period(3, s);
    repeat (20) tick();
    chk("stall_no_trig", trig_q.size(), 0);
    chk("stall_busy", busy, 1);
    chk("stall_i2s", i2s_enable, 0);
`ifdef AUD_SCHED_OVERRUN_EN
    cycle_start = 1'b1;
    tick();
    cycle_start = 1'b0;
    chk("stall_overrun", overrun, 1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("stall_overrun_clr", overrun, 0);
`endif
    fifo_level = CW'(63);
    f = cyc;
    finish_period(3, f + 1, "stall");

    // buffersize change after start has no effect
    fifo_level = CW'(0);
    start_period(5, s);
    buffersize = CW'(2);
    finish_period(5, s + 2, "bs_change");

    // Second cycle_start mid-period
    resp_dmin = 1;
    resp_dmax = 3;
    start_period(8, s);
    repeat (3) tick();
    cycle_start = 1'b1;
`ifdef AUD_SCHED_OVERRUN_EN
    overrun_clr = 1'b1;
`endif
    tick();
    cycle_start = 1'b0;
`ifdef AUD_SCHED_OVERRUN_EN
    overrun_clr = 1'b0;
    chk("overrun_set_wins", overrun, 1);
`endif
    finish_period(8, s + 2, "restart");
`ifdef AUD_SCHED_OVERRUN_EN
    chk("overrun_sticky", overrun, 1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("overrun_cleared", overrun, 0);
`endif

    // Largest legal buffersize
    resp_dmin = 0;
    resp_dmax = 2;
    start_period(127, s);
    finish_period(127, s + 2, "max");

    // Stray engine_done while idle
    tb_done = 1'b1;
    tick();
    tb_done = 1'b0;
    tick();
    chk("stray_count", sample_count, 127);
    chk("stray_busy", busy, 0);

    // I2S free-run mode
    resp_en    = 1'b0;
    buffersize = '0;
    tick();
    chk("i2s_enable", i2s_enable, 1);
    chk("i2s_busy", busy, 0);
    cycle_start = 1'b1;
    tick();
    cycle_start = 1'b0;
    repeat (2) tick();
    chk("i2s_start_ignored", busy, 0);
    trig_q.delete();
    for (int k = 0; k < 3; k++) begin
      lrck = 1'b1;
      r[k] = cyc;
      repeat (50) tick();
      lrck = 1'b0;
      repeat (50) tick();
    end
    chk("i2s_trigs", trig_q.size(), 3);
    for (int k = 0; k < 3; k++)
      if (k < trig_q.size()) chk($sformatf("i2s_lat%0d", k), trig_q[k], r[k] + 3);
    chk("i2s_enable_end", i2s_enable, 1);

    // Reset in WAIT with two samples produced
    resp_en   = 1'b1;
    resp_dmin = 5;
    resp_dmax = 5;
    start_period(6, s);
    for (n = 0; n < 500; n++) begin
      if (trig_q.size() == 3) break;
      tick();
    end
    chk("rst_mid_timeout", n < 500, 1);
    chk("rst_mid_count", sample_count, 2);
    chk("rst_mid_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async_trig", trig, 0);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_cycle_done", cycle_done, 0);
    chk("rst_async_count", sample_count, 0);
    chk("rst_async_i2s", i2s_enable, 0);
    repeat (10) tick();
    reset_n = 1'b1;
    tick();
    start_period(6, s);
    finish_period(6, s + 2, "post_reset");

    chk("no_consecutive_trig", double_trig, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_fill_sched.md
# audio_fill_sched

Sequencer for the synth-engine-to-audio-FIFO fill path. Once per host (JACK) period it issues one-cycle `trig` pulses to the sample engine until `buffersize` stereo samples have been produced. It throttles on FIFO room and reports completion. With `buffersize == 0` it falls back to I2S free-run mode, where `trig` follows LRCK. It sits between the host register block (which supplies `buffersize` and `cycle_start`) and the sample engine / L-R sample FIFOs.

## Interface
- `FIFO_WIDTH`, 6, FIFO depth is 2**FIFO_WIDTH stereo pairs; counts are FIFO_WIDTH+1 bits
- `TRIG_GAP`, 2, minimum idle cycles between `engine_done` and the next `trig` (0 allowed)
- `clk`  in  1  system clock; the only clock
- `reset_n`  in  1  asynchronous active-low reset
- `buffersize`  in  FIFO_WIDTH+1  samples per period; 0 selects I2S free-run mode
- `cycle_start`  in  1  one-cycle pulse, start of host period
- `lrck`  in  1  I2S word clock, asynchronous to `clk`
- `engine_done`  in  1  one-cycle pulse, engine finished one stereo sample
- `fifo_level`  in  FIFO_WIDTH+1  current stereo-pair fill of the sample FIFOs
- `trig`  out  1  one-cycle start pulse to the engine
- `i2s_enable`  out  1  high in I2S free-run mode
- `busy`  out  1  period fill in progress
- `cycle_done`  out  1  one-cycle pulse, period fill complete
- `sample_count`  out  FIFO_WIDTH+1  samples produced in the current or last period

## Operation
- FSM states: IDLE, TRIG, WAIT, GAP, DONE. Reset state is IDLE.
- IDLE:
  - `cycle_start` with `buffersize != 0`: latch `buffersize` into `bs_q`, clear `sample_count`, go to TRIG.
  - `cycle_start` with `buffersize == 0`: ignored.
- TRIG:
  - If `fifo_level < 2**FIFO_WIDTH`: register `trig = 1`, go to WAIT.
  - Otherwise stay in TRIG with `trig` low (stall), and keep re-checking every cycle.
- WAIT: on `engine_done`, increment `sample_count`.
  - If the new count equals `bs_q`, go to DONE.
  - Else, if `TRIG_GAP == 0`, go to TRIG.
  - Else go to GAP.
- GAP: count `TRIG_GAP` cycles, then go to TRIG.
- DONE: `cycle_done = 1` for exactly one cycle, then go to IDLE.
- Outputs:
  - `busy = (state != IDLE)`.
  - `i2s_enable = (state == IDLE) && (buffersize == 0)`.
- I2S mode:
  - `lrck` passes through a `syncro_2` two-flop synchronizer, then an edge-detect register.
  - In I2S mode `trig` = rising edge of synced LRCK; the FSM stays in IDLE.
- Boundary conditions:
  - `cycle_start` outside IDLE: ignored.
  - `engine_done` outside WAIT: ignored, no count change.
  - `buffersize` change while busy: no effect, because `bs_q` governs the period.
  - `buffersize` of all ones (2**(FIFO_WIDTH+1)-1) is legal; `sample_count` never wraps, since the period ends at `bs_q`.
  - Reset mid-period: the FSM returns to IDLE immediately and the period is abandoned.
- Reset values: `trig` 0, `busy` 0, `cycle_done` 0, `sample_count` 0, `i2s_enable` computed combinationally from IDLE state and `buffersize`, synchronizer and edge flops 0.

## Timing
- `cycle_start` sampled at edge k → state TRIG after k → `trig` high in the cycle after edge k+1, given FIFO room.
- `trig` is a registered single-cycle pulse and is never high on two consecutive cycles.
- `engine_done` may arrive in the same cycle `trig` is high; it is counted.
- From `engine_done` to the next `trig`:
  - `TRIG_GAP == 0`: 2 cycles.
  - Otherwise: TRIG_GAP + 2 cycles.
- Last `engine_done` → `cycle_done` in the following cycle; `busy` drops one cycle later.
- `lrck` rising edge → I2S `trig` after 3 `clk` cycles (2 synchronizer + 1 edge detect).

## Configuration
- `AUD_SCHED_OVERRUN_EN`. When defined, the block adds two ports:
  - `overrun_clr` (in, 1).
  - `overrun` (out, 1, sticky).
- `overrun` is set when `cycle_start` arrives while `busy`, or while the FSM is stalled in TRIG at the arrival of `cycle_start`.
- `overrun_clr` clears `overrun`; a simultaneous set wins.
- When the macro is undefined, these ports and their logic are absent, and `cycle_start` while busy is silently ignored.

## Structure
- Shared package `audio_pkg`: state enum `sched_state_t`, the default `FIFO_WIDTH`, and `SYNC_LATENCY = 2`.
- One sub-module: the existing `syncro_2` for LRCK.
- The FSM, counters and edge detect are inline.

## Test plan
- `buffersize=4`, `TRIG_GAP=2`, engine answers `engine_done` 5 cycles after each `trig` → exactly 4 `trig` pulses, then one `cycle_done`; `sample_count=4`; `busy` falls one cycle after `cycle_done`.
- `buffersize=3`, `fifo_level=64` held 20 cycles after start → no `trig` during the stall; first `trig` exactly 1 cycle after `fifo_level` drops to 63.
- `buffersize=0`, toggle `lrck` with period 100 cycles → one `trig` per rising edge, each 3 cycles after the edge; `i2s_enable=1`; `busy=0`.
- Second `cycle_start` mid-period with `buffersize=8` (macro on) → still exactly 8 trigs; `overrun=1` until `overrun_clr`.
- `buffersize` changed from 5 to 2 after start → still 5 trigs.
- `reset_n` low during WAIT with `sample_count=2` → all outputs 0 asynchronously; next `cycle_start` produces a full period from count 0.
